mem_lsu: RTL and testbench

- Load/store unit in the memory stage, directly downstream of the execute ALU.
- Consumes the ALU result as the effective address (loads/stores) or as the writeback value (all other ops).
- Drives a word-wide req/gnt/rvalid data-memory bus and formats load data (byte/half/word, signed/unsigned) for writeback.
- Stalls the upstream pipeline via `in_rdy` while a memory transaction is outstanding.

---
 rtl/mem_lsu_pkg.sv | 38 +++
 rtl/mem_lsu_fmt.sv | 53 +++++
 rtl/mem_lsu.sv | 158 +++++++++++++++
 tb/tb_mem_lsu.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Contents: opcode and funct3 constants, the FSM state type and a
// misalignment helper used by the optional trap build
// (MEM_LSU_MISALIGN_TRAP_EN).
package mem_lsu_pkg;

  localparam int unsigned OPW = 7;
  localparam int unsigned F3W = 3;

  localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPW-1:0] OP_STORE = 7'b0100011;
  localparam logic [OPW-1:0] OP_RR    = 7'b0110011;

  localparam logic [F3W-1:0] F3_LB  = 3'b000;
  localparam logic [F3W-1:0] F3_LH  = 3'b001;
  localparam logic [F3W-1:0] F3_LW  = 3'b010;
  localparam logic [F3W-1:0] F3_LBU = 3'b100;
  localparam logic [F3W-1:0] F3_LHU = 3'b101;
  localparam logic [F3W-1:0] F3_SB  = 3'b000;
  localparam logic [F3W-1:0] F3_SH  = 3'b001;
  localparam logic [F3W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // funct3[1:0] is the access size: 0 byte, 1 half, otherwise word.
  function automatic logic misaligned(input logic [F3W-1:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational data formatter for the load/store unit.
// Ports: funct3/addr_lo select size, lane and sign; rs2 is raw store data;
// rdata is the raw bus word. Outputs: be (byte enables), wdata
// (lane-replicated store data), ld_data (extracted, extended load value).
// Misaligned half/word offsets are forced down to natural alignment.
module mem_lsu_fmt
  import mem_lsu_pkg::*;
(
  input  logic [F3W-1:0] funct3,
  input  logic [1:0]     addr_lo,
  input  logic [31:0]    rs2,
  input  logic [31:0]    rdata,
  output logic [3:0]     be,
  output logic [31:0]    wdata,
  output logic [31:0]    ld_data
);

  logic [1:0]  a;
  logic [31:0] shifted;

  always_comb begin
    a       = 2'b00;
    shifted = 32'h0;
    be      = 4'b1111;
    wdata   = rs2;
    ld_data = rdata;
    // Effective lane offset after alignment forcing.
    case (funct3[1:0])
      2'b00:   a = addr_lo;
      2'b01:   a = {addr_lo[1], 1'b0};
      default: a = 2'b00;
    endcase
    shifted = rdata >> {a, 3'b000};
    case (funct3[1:0])
      2'b00: begin
        be      = 4'(4'b0001 << a);
        wdata   = {4{rs2[7:0]}};
        ld_data = funct3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be      = 4'(4'b0011 << a);
        wdata   = {2{rs2[15:0]}};
        ld_data = funct3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be      = 4'b1111;
        wdata   = rs2;
        ld_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit.
// Takes the execute-stage result; loads/stores use it as the byte address
// on a req/gnt/rvalid word bus, other ops pass it straight to writeback.
// Ports: clk/rst (sync, active-high); in_* upstream handshake and operands;
// flush kills the current/pending instruction; mem_* data-memory bus;
// wb_* one-cycle writeback pulse; trap_misalign pulses on a misaligned
// access only when MEM_LSU_MISALIGN_TRAP_EN is defined (else held 0).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [OPW-1:0] in_opcode,
  input  logic [F3W-1:0] in_funct3,
  input  logic [DW-1:0]  in_alu_y,
  input  logic [DW-1:0]  in_rs2,
  input  logic [4:0]     in_rd,
  input  logic           flush,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [3:0]     mem_be,
  output logic [DW-1:0]  mem_wdata,
  input  logic           mem_gnt,
  input  logic           mem_rvalid,
  input  logic [DW-1:0]  mem_rdata,
  output logic           wb_vld,
  output logic [4:0]     wb_rd,
  output logic [DW-1:0]  wb_data,
  output logic           trap_misalign
);

  lsu_state_t     state;
  logic [F3W-1:0] f3_q;
  logic [1:0]     alo_q;
  logic [4:0]     rd_q;
  logic           kill_q;

  logic           is_ld;
  logic           is_st;
  logic           trap_hit;
  logic [F3W-1:0] fmt_f3;
  logic [1:0]     fmt_alo;
  logic [3:0]     fmt_be;
  logic [DW-1:0]  fmt_wdata;
  logic [DW-1:0]  fmt_ld;

  assign is_ld = (in_opcode == OP_LOAD);
  assign is_st = (in_opcode == OP_STORE);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign trap_hit = (is_ld | is_st) & misaligned(in_funct3, in_alu_y[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  // Formatter sees live operands at acceptance and latched ones on load return.
  assign fmt_f3  = (state == IDLE) ? in_funct3     : f3_q;
  assign fmt_alo = (state == IDLE) ? in_alu_y[1:0] : alo_q;

  mem_lsu_fmt u_fmt (
    .funct3  (fmt_f3),
    .addr_lo (fmt_alo),
    .rs2     (in_rs2),
    .rdata   (mem_rdata),
    .be      (fmt_be),
    .wdata   (fmt_wdata),
    .ld_data (fmt_ld)
  );

  // FSM with registered bus and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_rdy        <= 1'b1;
      f3_q          <= '0;
      alo_q         <= '0;
      rd_q          <= '0;
      kill_q        <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      wb_vld        <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      trap_misalign <= 1'b0;
    end else begin
      wb_vld        <= 1'b0;
      trap_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (in_vld && !flush) begin
            if (trap_hit) begin
              trap_misalign <= 1'b1;
            end else if (is_ld || is_st) begin
              state     <= REQ;
              in_rdy    <= 1'b0;
              f3_q      <= in_funct3;
              alo_q     <= in_alu_y[1:0];
              rd_q      <= in_rd;
              kill_q    <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= is_st;
              mem_addr  <= {in_alu_y[AW-1:2], 2'b00};
              mem_be    <= fmt_be;
              mem_wdata <= is_st ? fmt_wdata : '0;
            end else begin
              wb_vld  <= 1'b1;
              wb_rd   <= in_rd;
              wb_data <= in_alu_y;
            end
          end
        end
        REQ: begin
          if (flush) begin
            state   <= IDLE;
            in_rdy  <= 1'b1;
            mem_req <= 1'b0;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state  <= IDLE;
              in_rdy <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A load already granted must drain; flush only hides its result.
          if (flush) kill_q <= 1'b1;
          if (mem_rvalid) begin
            state  <= IDLE;
            in_rdy <= 1'b1;
            if (!kill_q && !flush) begin
              wb_vld  <= 1'b1;
              wb_rd   <= rd_q;
              wb_data <= fmt_ld;
            end
          end
        end
        default: begin
          state   <= IDLE;
          in_rdy  <= 1'b1;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expected writebacks and bus
// requests into queues; a negedge monitor pops and compares them.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_alu_y = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        trap_misalign;

  mem_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .in_opcode     (in_opcode),
    .in_funct3     (in_funct3),
    .in_alu_y      (in_alu_y),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .wb_vld        (wb_vld),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .trap_misalign (trap_misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  wb_t  wb_e;
  bus_t bus_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every writeback pulse and every granted request is checked.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_vld) begin
        if (wb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual rd=%0d data=0x%08h required=no pulse", wb_rd, wb_data);
        end else begin
          wb_e = wb_q.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(wb_e.rd));
          chk("wb_data", wb_data, wb_e.data);
        end
      end
      if (mem_req && mem_gnt) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected actual addr=0x%08h required=no request", mem_addr);
        end else begin
          bus_e = bus_q.pop_front();
          chk("bus_addr", mem_addr, bus_e.addr);
          chk("bus_be", 32'(mem_be), 32'(bus_e.be));
          chk("bus_wdata", mem_wdata, bus_e.wdata);
          chk("bus_we", 32'(mem_we), 32'(bus_e.we));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] y,
                       input logic [31:0] rs2v, input logic [4:0] rd);
    in_vld    = 1'b1;
    in_opcode = op;
    in_funct3 = f3;
    in_alu_y  = y;
    in_rs2    = rs2v;
    in_rd     = rd;
    tick();
    in_vld    = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    bus_q.push_back('{addr: exp_addr, be: exp_be, wdata: 32'h0, we: 1'b0});
    wb_q.push_back('{rd: rd, data: exp_data});
    issue(OP_LOAD, f3, addr, 32'h0, rd);
    chk("ld_rdy_low", 32'(in_rdy), 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("ld_req_drop", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk("ld_rdy_back", 32'(in_rdy), 32'd1);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2v,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int gnt_wait);
    int req_cycles;
    req_cycles = 0;
    bus_q.push_back('{addr: exp_addr, be: exp_be, wdata: exp_wdata, we: 1'b1});
    issue(OP_STORE, f3, addr, rs2v, 5'd0);
    for (int i = 0; i < gnt_wait; i++) begin
      if (mem_req) req_cycles++;
      chk("st_rdy_low", 32'(in_rdy), 32'd0);
      chk("st_hold_addr", mem_addr, exp_addr);
      chk("st_hold_be", 32'(mem_be), 32'(exp_be));
      chk("st_hold_wdata", mem_wdata, exp_wdata);
      tick();
    end
    if (mem_req) req_cycles++;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("st_req_cycles", 32'(req_cycles), 32'(gnt_wait + 1));
    chk("st_req_drop", 32'(mem_req), 32'd0);
    chk("st_rdy_back", 32'(in_rdy), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_trap", 32'(trap_misalign), 32'd0);

    // ALU pass-through and back-to-back acceptance, including rd=0.
    wb_q.push_back('{rd: 5'd5, data: 32'h0000_1234});
    issue(OP_RR, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    chk("alu_in_rdy", 32'(in_rdy), 32'd1);
    wb_q.push_back('{rd: 5'd0, data: 32'hDEAD_0001});
    issue(OP_RR, 3'b000, 32'hDEAD_0001, 32'h0, 5'd0);
    tick();

    // Loads: signed byte, unsigned half, signed half, unsigned byte.
    do_load(F3_LB,  32'h103, 5'd7,  32'h80FF_FF00, 32'h100, 4'b1000, 32'hFFFF_FF80);
    do_load(F3_LHU, 32'h202, 5'd8,  32'hBEEF_0000, 32'h200, 4'b1100, 32'h0000_BEEF);
    do_load(F3_LH,  32'h302, 5'd9,  32'h8001_0000, 32'h300, 4'b1100, 32'hFFFF_8001);
    do_load(F3_LBU, 32'h401, 5'd10, 32'h1234_F600, 32'h400, 4'b0010, 32'h0000_00F6);

    // Stores: byte with 3-cycle grant stall, half, word.
    do_store(F3_SB, 32'h11, 32'h0000_00A5, 32'h10, 4'b0010, 32'hA5A5_A5A5, 3);
    do_store(F3_SH, 32'h22, 32'h1234_BEEF, 32'h20, 4'b1100, 32'hBEEF_BEEF, 0);
    do_store(F3_SW, 32'h30, 32'hCAFE_F00D, 32'h30, 4'b1111, 32'hCAFE_F00D, 1);

    // Flush while the request is ungranted.
    issue(OP_LOAD, F3_LW, 32'h40, 32'h0, 5'd3);
    chk("flreq_req_up", 32'(mem_req), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flreq_req_drop", 32'(mem_req), 32'd0);
    chk("flreq_rdy", 32'(in_rdy), 32'd1);

    // Flush while waiting for read data: result must be swallowed.
    bus_q.push_back('{addr: 32'h80, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    issue(OP_LOAD, F3_LW, 32'h80, 32'h0, 5'd4);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flwait_rdy_low", 32'(in_rdy), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    chk("flwait_rdy", 32'(in_rdy), 32'd1);

    // Flush together with in_vld in IDLE drops the instruction.
    in_vld = 1'b1;
    flush  = 1'b1;
    in_opcode = OP_RR;
    in_alu_y  = 32'h5555_5555;
    tick();
    in_vld = 1'b0;
    flush  = 1'b0;
    chk("flidle_req", 32'(mem_req), 32'd0);

    // Stray rvalid and gnt while idle are ignored.
    mem_rvalid = 1'b1;
    mem_gnt    = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    chk("stray_rdy", 32'(in_rdy), 32'd1);

    // Reset mid-transaction, then a late rvalid.
    bus_q.push_back('{addr: 32'h90, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    issue(OP_LOAD, F3_LW, 32'h90, 32'h0, 5'd6);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rdy", 32'(in_rdy), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;

    // Misaligned word access.
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    issue(OP_LOAD, F3_LW, 32'h6, 32'h0, 5'd11);
    chk("trap_pulse", 32'(trap_misalign), 32'd1);
    chk("trap_no_req", 32'(mem_req), 32'd0);
    chk("trap_rdy", 32'(in_rdy), 32'd1);
    tick();
    chk("trap_clear", 32'(trap_misalign), 32'd0);
`else
    do_load(F3_LW, 32'h6, 5'd11, 32'hCAFE_F00D, 32'h4, 4'b1111, 32'hCAFE_F00D);
    chk("notrap", 32'(trap_misalign), 32'd0);
`endif

    repeat (3) tick();
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
